// File: rtl/mem_access_unit.sv
// Multi-cycle load/store unit over a private word array with error, halt and
// fixed-latency access sequencing for an in-order pipeline.
module mem_access_unit #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic              halt,
  output logic [DATA_W-1:0] wb_data,
  output logic              stall,
  output logic              done,
  output logic              err,
  output logic              halted
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    DONE   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               pend_q;
  logic [IDX_W-1:0]   idx_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  ld_q;
  logic               is_load_q;
  logic               accept;
  logic               stall_i;
  logic               err_i;
  logic               last_beat;

  logic [DATA_W-1:0]  mem [DEPTH];

  // Bits above the word index only select an alias of the array.
  generate
    if (ADDR_W > IDX_W + 1) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^addr[ADDR_W-1:IDX_W+1];
    end
  endgenerate

  assign last_beat = (state_q == BUSY) && (cnt_q == CNT_LAST);

  // Next-state and request decode; halt outranks any request in IDLE.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    stall_i = 1'b0;
    err_i   = 1'b0;
    case (state_q)
      IDLE: begin
        if (halt) begin
          state_d = HALTED;
        end else if (rd_en && wr_en) begin
          err_i = 1'b1;
        end else if (rd_en || wr_en) begin
          if (addr[0]) begin
            err_i = 1'b1;
          end else begin
            accept  = 1'b1;
            stall_i = 1'b1;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        stall_i = 1'b1;
        if (cnt_q == CNT_LAST) state_d = DONE;
      end
      DONE: begin
        state_d = (halt || pend_q) ? HALTED : IDLE;
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      ld_q      <= '0;
      is_load_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q     <= '0;
        pend_q    <= 1'b0;
        idx_q     <= addr[IDX_W:1];
        wdata_q   <= wdata;
        is_load_q <= rd_en;
      end else if (state_q == BUSY) begin
        cnt_q <= cnt_q + CNT_W'(1);
        if (halt) pend_q <= 1'b1;
      end
      if (last_beat && is_load_q) ld_q <= mem[idx_q];
    end
  end

  // Array has no reset; a reset mid-access drops the state out of BUSY first.
  always_ff @(posedge clk) begin
    if (last_beat && !is_load_q) mem[idx_q] <= wdata_q;
  end

  // Combinational request responses are forced low while reset is held.
  assign stall   = rst & stall_i;
  assign err     = rst & err_i;
  assign done    = (state_q == DONE);
  assign halted  = (state_q == HALTED);
  assign wb_data = ((state_q == DONE) && is_load_q) ? ld_q : alu_result;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit: default instance plus a
// DATA_W=32 pair at LAT=1 and LAT=5, all checked against an array model.
module tb_mem_access_unit;

  localparam int L0 = 2;
  localparam int L1 = 1;
  localparam int L2 = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] addr0, wdata0, alu0, wb0;
  logic        rd0, wr0, halt0, stall0, done0, err0, halted0;

  logic [15:0] addr_s;
  logic [31:0] wdata_s, alu_s, wb1, wb2;
  logic        rd1, wr1, rd2, wr2, halt_s;
  logic        stall1, done1, err1, halted1, stall2, done2, err2, halted2;

  mem_access_unit u0 (
    .clk(clk), .rst(rst), .addr(addr0), .wdata(wdata0), .alu_result(alu0),
    .rd_en(rd0), .wr_en(wr0), .halt(halt0), .wb_data(wb0), .stall(stall0),
    .done(done0), .err(err0), .halted(halted0)
  );

  mem_access_unit #(.DATA_W(32), .LAT(L1)) u1 (
    .clk(clk), .rst(rst), .addr(addr_s), .wdata(wdata_s), .alu_result(alu_s),
    .rd_en(rd1), .wr_en(wr1), .halt(halt_s), .wb_data(wb1), .stall(stall1),
    .done(done1), .err(err1), .halted(halted1)
  );

  mem_access_unit #(.DATA_W(32), .LAT(L2)) u2 (
    .clk(clk), .rst(rst), .addr(addr_s), .wdata(wdata_s), .alu_result(alu_s),
    .rd_en(rd2), .wr_en(wr2), .halt(halt_s), .wb_data(wb2), .stall(stall2),
    .done(done2), .err(err2), .halted(halted2)
  );

  // Reference memories: word index is (byte address / 2) mod 256.
  logic [15:0] m0 [256];
  bit          v0 [256];
  logic [31:0] ms [2][256];
  bit          vs [2][256];

  int vec  = 0;
  int miss = 0;

  // One u0 access from a drive point; halt pulses for one cycle at halt_cyc.
  task automatic access0(input bit ld, input logic [15:0] a, input logic [15:0] d,
                         input int halt_cyc);
    int idx;
    logic [15:0] alu;
    idx  = (int'(a) / 2) % 256;
    alu  = 16'($urandom);
    rd0 = ld; wr0 = !ld; addr0 = a; wdata0 = d; alu0 = alu;
    for (int c = 0; c <= L0 + 1; c++) begin
      halt0 = (c == halt_cyc);
      @(negedge clk);
      vec++;
      if (stall0 !== (c <= L0) || done0 !== (c == L0 + 1) || err0 !== 1'b0 || halted0 !== 1'b0) begin
        miss++;
        $display("FAIL access0 a=%h cyc=%0d: stall=%b done=%b err=%b halted=%b, want stall=%b done=%b err=0 halted=0",
                 a, c, stall0, done0, err0, halted0, (c <= L0), (c == L0 + 1));
      end
      if (c == L0 + 1) begin
        if (ld && v0[idx]) begin
          vec++;
          if (wb0 !== m0[idx]) begin
            miss++;
            $display("FAIL load0 a=%h: wb_data=%h want %h", a, wb0, m0[idx]);
          end
        end else if (!ld) begin
          vec++;
          if (wb0 !== alu) begin
            miss++;
            $display("FAIL store0_wb a=%h: wb_data=%h want alu %h", a, wb0, alu);
          end
          m0[idx] = d;
          v0[idx] = 1'b1;
        end
      end
      @(posedge clk); #1;
    end
    rd0 = 1'b0; wr0 = 1'b0; halt0 = 1'b0;
  endtask

  // One access on u1 (k=0) or u2 (k=1) from a drive point.
  task automatic access_s(input int k, input bit ld, input logic [15:0] a, input logic [31:0] d);
    int lat, idx;
    logic [31:0] alu, wb;
    logic st, dn, er;
    lat = (k == 0) ? L1 : L2;
    idx = (int'(a) / 2) % 256;
    alu = $urandom;
    addr_s = a; wdata_s = d; alu_s = alu;
    if (k == 0) begin rd1 = ld; wr1 = !ld; end else begin rd2 = ld; wr2 = !ld; end
    for (int c = 0; c <= lat + 1; c++) begin
      @(negedge clk);
      if (k == 0) begin st = stall1; dn = done1; er = err1; wb = wb1; end
      else        begin st = stall2; dn = done2; er = err2; wb = wb2; end
      vec++;
      if (st !== (c <= lat) || dn !== (c == lat + 1) || er !== 1'b0) begin
        miss++;
        $display("FAIL sweep lat=%0d a=%h cyc=%0d: stall=%b done=%b err=%b, want stall=%b done=%b err=0",
                 lat, a, c, st, dn, er, (c <= lat), (c == lat + 1));
      end
      if (c == lat + 1) begin
        if (ld && vs[k][idx]) begin
          vec++;
          if (wb !== ms[k][idx]) begin
            miss++;
            $display("FAIL sweep_load lat=%0d a=%h: wb_data=%h want %h", lat, a, wb, ms[k][idx]);
          end
        end else if (!ld) begin
          ms[k][idx] = d;
          vs[k][idx] = 1'b1;
        end
      end
      @(posedge clk); #1;
    end
    rd1 = 1'b0; wr1 = 1'b0; rd2 = 1'b0; wr2 = 1'b0;
  endtask

  task automatic test_reset();
    rd0 = 1'b1; wr0 = 1'b1; addr0 = 16'h0003;
    @(negedge clk);
    vec++;
    if (stall0 !== 1'b0 || done0 !== 1'b0 || err0 !== 1'b0 || halted0 !== 1'b0) begin
      miss++;
      $display("FAIL reset_u0: stall=%b done=%b err=%b halted=%b want all 0", stall0, done0, err0, halted0);
    end
    vec++;
    if ({stall1, done1, err1, halted1, stall2, done2, err2, halted2} !== 8'h00) begin
      miss++;
      $display("FAIL reset_sweep: flags=%b want 00000000",
               {stall1, done1, err1, halted1, stall2, done2, err2, halted2});
    end
    @(posedge clk); #1;
    rd0 = 1'b0; wr0 = 1'b0; rst = 1'b1;
  endtask

  task automatic test_store_load();
    access0(1'b0, 16'h0010, 16'hBEEF, -1);
    access0(1'b1, 16'h0010, 16'h0000, -1);
  endtask

  task automatic test_errors();
    logic [15:0] ea [3];
    logic        er [3];
    logic        ew [3];
    ea[0] = 16'h0040; er[0] = 1'b1; ew[0] = 1'b1;
    ea[1] = 16'h0011; er[1] = 1'b1; ew[1] = 1'b0;
    ea[2] = 16'h0041; er[2] = 1'b0; ew[2] = 1'b1;
    access0(1'b0, 16'h0040, 16'h5A5A, -1);
    for (int i = 0; i < 3; i++) begin
      rd0 = er[i]; wr0 = ew[i]; addr0 = ea[i]; wdata0 = 16'hFFFF;
      @(negedge clk);
      vec++;
      if (err0 !== 1'b1 || stall0 !== 1'b0 || done0 !== 1'b0) begin
        miss++;
        $display("FAIL err_pulse case=%0d: err=%b stall=%b done=%b want 1 0 0", i, err0, stall0, done0);
      end
      @(posedge clk); #1;
      rd0 = 1'b0; wr0 = 1'b0;
      @(negedge clk);
      vec++;
      if (err0 !== 1'b0 || stall0 !== 1'b0 || done0 !== 1'b0) begin
        miss++;
        $display("FAIL err_after case=%0d: err=%b stall=%b done=%b want 0 0 0", i, err0, stall0, done0);
      end
      @(posedge clk); #1;
    end
    access0(1'b1, 16'h0040, 16'h0000, -1);
  endtask

  task automatic test_wrap();
    access0(1'b0, 16'h0202, 16'h1234, -1);
    access0(1'b1, 16'h0002, 16'h0000, -1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++)
      access0(i[0], 16'h0080 + 16'(i / 2) * 16'd2, 16'($urandom), -1);
  endtask

  task automatic test_random();
    int op;
    logic [15:0] a, alu;
    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 5);
      a  = 16'($urandom_range(0, 127) * 512 + $urandom_range(0, 15) * 2);
      if (op >= 3) begin
        access0(op == 3, a, 16'($urandom), -1);
      end else begin
        alu = 16'($urandom); alu0 = alu; addr0 = a; wdata0 = 16'($urandom);
        rd0 = (op == 1) || (op == 2 && a[9]);
        wr0 = (op == 1) || (op == 2 && !a[9]);
        if (op == 2) addr0 = a | 16'h0001;
        @(negedge clk);
        vec++;
        if (err0 !== (op != 0) || stall0 !== 1'b0 || done0 !== 1'b0 || wb0 !== alu) begin
          miss++;
          $display("FAIL rand_idle op=%0d: err=%b stall=%b done=%b wb=%h want err=%b stall=0 done=0 wb=%h",
                   op, err0, stall0, done0, wb0, (op != 0), alu);
        end
        @(posedge clk); #1;
        rd0 = 1'b0; wr0 = 1'b0;
      end
    end
  endtask

  task automatic halted_cycles(input int n);
    logic [15:0] alu;
    for (int i = 0; i < n; i++) begin
      alu = 16'($urandom); alu0 = alu;
      rd0 = 1'($urandom); wr0 = 1'($urandom); addr0 = 16'($urandom);
      @(negedge clk);
      vec++;
      if (halted0 !== 1'b1 || stall0 !== 1'b0 || done0 !== 1'b0 || err0 !== 1'b0 || wb0 !== alu) begin
        miss++;
        $display("FAIL halted: halted=%b stall=%b done=%b err=%b wb=%h want 1 0 0 0 %h",
                 halted0, stall0, done0, err0, wb0, alu);
      end
      @(posedge clk); #1;
    end
    rd0 = 1'b0; wr0 = 1'b0;
    rst = 1'b0;
    #1;
    vec++;
    if (halted0 !== 1'b0 || stall0 !== 1'b0) begin
      miss++;
      $display("FAIL halt_reset: halted=%b stall=%b want 0 0", halted0, stall0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_halt();
    int hc [3];
    logic [15:0] a;
    hc[0] = 1; hc[1] = L0; hc[2] = L0 + 1;
    rd0 = 1'b1; wr0 = 1'b1; addr0 = 16'h0007; halt0 = 1'b1;
    @(negedge clk);
    vec++;
    if (err0 !== 1'b0 || stall0 !== 1'b0 || halted0 !== 1'b0) begin
      miss++;
      $display("FAIL halt_idle: err=%b stall=%b halted=%b want 0 0 0", err0, stall0, halted0);
    end
    @(posedge clk); #1;
    halt0 = 1'b0;
    halted_cycles(3);
    for (int i = 0; i < 3; i++) begin
      a = (i == 0) ? 16'h0030 : 16'($urandom_range(0, 255) * 2);
      access0(1'b0, a, 16'($urandom), hc[i]);
      halted_cycles(4);
      access0(1'b1, a, 16'h0000, -1);
    end
  endtask

  task automatic test_reset_busy();
    access0(1'b0, 16'h0020, 16'hCAFE, -1);
    wr0 = 1'b1; addr0 = 16'h0020; wdata0 = 16'hDEAD;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    vec++;
    if (stall0 !== 1'b0 || done0 !== 1'b0 || err0 !== 1'b0 || halted0 !== 1'b0) begin
      miss++;
      $display("FAIL reset_busy: stall=%b done=%b err=%b halted=%b want all 0", stall0, done0, err0, halted0);
    end
    wr0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    access0(1'b1, 16'h0020, 16'h0000, -1);
  endtask

  task automatic test_sweep();
    logic [31:0] alu;
    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 12; n++) begin
        access_s(k, (n >= 4) && 1'($urandom), 16'($urandom_range(0, 127) * 512 + $urandom_range(0, 7) * 2),
                 $urandom);
        alu = $urandom; alu_s = alu;
        @(negedge clk);
        vec++;
        if (wb1 !== alu || wb2 !== alu || done1 !== 1'b0 || done2 !== 1'b0) begin
          miss++;
          $display("FAIL sweep_idle: wb1=%h wb2=%h done1=%b done2=%b want wb=%h done=0", wb1, wb2, done1, done2, alu);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    addr0 = '0; wdata0 = '0; alu0 = '0; rd0 = 1'b0; wr0 = 1'b0; halt0 = 1'b0;
    addr_s = '0; wdata_s = '0; alu_s = '0; halt_s = 1'b0;
    rd1 = 1'b0; wr1 = 1'b0; rd2 = 1'b0; wr2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_store_load();
    test_errors();
    test_wrap();
    test_back_to_back();
    test_random();
    test_halt();
    test_reset_busy();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
